uart16550_tx: RTL and testbench
===============================

UART16550_TX -- requirements
Module: uart16550_tx

Interface
REQ-001 Parameters: none; all character format comes from csr_i.lcr.
REQ-002 clk_i  input  1  Single clock, rising edge.
REQ-003 rst_ni  input  1  Reset, synchronous, active-low.
REQ-004 baudout_i  input  1  Baud-rate enable, one clk_i pulse per 1/16 bit time.
REQ-005 csr_i  input  csr_t  CSR bundle; uses lcr.wls, lcr.stb, lcr.pen, lcr.eps, lcr.stick_parity, lcr.bc.
REQ-006 empty_i  input  1  TX FIFO/THR empty.
REQ-007 d_i  input  8  TX FIFO head data, first-word-fall-through, valid while empty_i=0.
REQ-008 pop_o  output  1  One-clk pulse that consumes the FIFO head.
REQ-009 temt_o  output  1  Transmitter empty: FSM in ST_IDLE and empty_i=1.
REQ-010 sout_o  output  1  Serial output, idle high.

Function
REQ-011 FSM states: ST_IDLE, ST_START, ST_BYTE, ST_PARITY, ST_STOP. All state, counter and output updates occur only on clk_i edges with baudout_i=1, except pop_o clearing and reset.
REQ-012 ST_IDLE with empty_i=0 and a baudout_i tick: pop_o=1 for exactly that one clk, capture d_i and the lcr fields wls/pen/eps/stick_parity/stb into shadow registers, load cnt=15, and go to ST_START. Each bit lasts 16 ticks.
REQ-013 The shadow lcr fields govern the whole character; csr_i changes mid-character take effect on the next character.
REQ-014 ST_START: sout_o=0. At cnt=0, go to ST_BYTE, set bitcnt=wls+4, and reload cnt=15.
REQ-015 ST_BYTE: sout_o=shifted data LSB, data bits LSB first. At cnt=0, shift right. When bitcnt=0, go to ST_PARITY if pen=1, else ST_STOP; otherwise decrement bitcnt.
REQ-016 Parity uses only the wls data bits; upper bits are masked to 0. {stick,eps} selects the parity bit value:
  - 00: ~^data (odd parity)
  - 01: ^data (even parity)
  - 10: 1
  - 11: 0
REQ-017 ST_PARITY lasts 16 ticks, then goes to ST_STOP.
REQ-018 ST_STOP: sout_o=1. Stop length:
  - stb=0: 16 ticks
  - stb=1 and wls=5 bits: 24 ticks
  - stb=1 otherwise: 32 ticks
  Use a 5-bit stop counter or an equivalent reload.
REQ-019 At the end of ST_STOP, go to ST_IDLE. If empty_i=0 on the next tick, start immediately; no extra idle bit-time is inserted.
REQ-020 Break (lcr.bc=1): sout_o=0 regardless of state. The FSM continues transmitting unaffected. sout_o resumes the FSM value on the first clk after bc clears.
REQ-021 If empty_i rises during a character, the character still completes. pop_o never asserts while empty_i=1.
REQ-022 temt_o is combinational from state and empty_i, and is 0 from the pop cycle until stop completes.
REQ-023 sout_o is registered, with no glitches between bits.

Reset
REQ-024 rst_ni=0 at a clk_i edge sets: state=ST_IDLE, sout_o=1, pop_o=0, cnt=0, bitcnt=0, shadow registers=0. This holds mid-character too: the line returns high on the next edge and the partial character is discarded, not re-popped.
REQ-025 temt_o after reset equals empty_i.

Structure
REQ-026 csr_t, the wls encoding (wls_5bits..wls_8bits) and a tx_state_t enum belong in uart16550_pkg.
REQ-027 No sub-module; parity is a local function.

Verification
REQ-028 8N1, d_i=0x55 popped: sout_o = 0,1,0,1,0,1,0,1,0,1, each level 16 ticks; one pop_o pulse; temt_o=1 after 160 ticks.
REQ-029 7E1, d_i=0xA3 (7-bit value 0x23, three ones): parity bit=1; 0xA3 bit7 is not transmitted; frame is 10 bits (160 ticks).
REQ-030 5 bits, stb=1, pen=0, d_i=0x1F: stop high for exactly 24 ticks. Same with wls=8 bits: 32 ticks.
REQ-031 Two FIFO entries 0x00 then 0xFF, 8N1: second start bit begins on the tick after the first stop ends; exactly two pop_o pulses.
REQ-032 bc=1 asserted mid-byte: sout_o=0 until bc=0, and the FSM ends at the same tick count as without break. Stick parity {1,0} with pen=1 sends parity=1.
REQ-033 rst_ni=0 during ST_BYTE: sout_o=1 and pop_o=0 at the next edge; no further pop until empty_i=0 after reset.

Source files
------------

// File: rtl/uart16550_pkg.sv
// Shared types for the 16550-style transmitter.
//   wls_t      : word length select encoding (5..8 data bits)
//   lcr_t      : line control fields the transmitter consumes
//   csr_t      : CSR bundle handed to the transmitter
//   tx_state_t : transmit FSM state encoding
package uart16550_pkg;

   typedef enum logic [1:0] {
      wls_5bits = 2'b00,
      wls_6bits = 2'b01,
      wls_7bits = 2'b10,
      wls_8bits = 2'b11
   } wls_t;

   typedef struct packed {
      logic bc;
      logic stick_parity;
      logic eps;
      logic pen;
      logic stb;
      wls_t wls;
   } lcr_t;

   typedef struct packed {
      lcr_t lcr;
   } csr_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_BYTE   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Tick counts minus one (counters run down to zero inclusive).
   localparam logic [4:0] BIT_TICKS_M1  = 5'd15;
   localparam logic [4:0] STOP_1P5_M1   = 5'd23;
   localparam logic [4:0] STOP_2_M1     = 5'd31;

endpackage

// File: rtl/uart16550_tx.sv
// 16550-style serial transmitter.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | line high, waiting for a tick with FIFO non-empty
//   ST_START  | start bit (low), 16 ticks
//   ST_BYTE   | data bits LSB first, 16 ticks each
//   ST_PARITY | parity bit, 16 ticks
//   ST_STOP   | stop bit(s) high, 16 / 24 / 32 ticks
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset
//   baudout_i  : 16x baud enable (one clk pulse per 1/16 bit)
//   csr_i      : CSR bundle (lcr fields)
//   empty_i    : TX FIFO empty
//   d_i        : TX FIFO head (first-word-fall-through)
//   pop_o      : one-clk pulse consuming the FIFO head
//   temt_o     : transmitter fully empty
//   sout_o     : serial line, idle high
module uart16550_tx
   import uart16550_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       baudout_i,
   input  csr_t       csr_i,
   input  logic       empty_i,
   input  logic [7:0] d_i,
   output logic       pop_o,
   output logic       temt_o,
   output logic       sout_o
);

   tx_state_t  state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   wls_t       wls_q, wls_d;
   logic       pen_q, pen_d;
   logic       stb_q, stb_d;
   logic       pop_q, pop_d;
   logic       sout_q, sout_d;

   // Parity over the selected word length only; bits above it are masked.
   function automatic logic parity_bit(input logic [7:0] data, input wls_t wls,
                                       input logic eps, input logic stick);
      logic [7:0] m;
      m = data;
      case (wls)
         wls_5bits: m = data & 8'h1F;
         wls_6bits: m = data & 8'h3F;
         wls_7bits: m = data & 8'h7F;
         wls_8bits: m = data;
         default:   m = data;
      endcase
      case ({stick, eps})
         2'b00:   return ~^m;
         2'b01:   return ^m;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [4:0] stop_reload(input logic stb, input wls_t wls);
      if (!stb)                 return BIT_TICKS_M1;
      else if (wls == wls_5bits) return STOP_1P5_M1;
      else                      return STOP_2_M1;
   endfunction

   function automatic logic line_level(input tx_state_t st, input logic dbit,
                                       input logic par);
      case (st)
         ST_START:  return 1'b0;
         ST_BYTE:   return dbit;
         ST_PARITY: return par;
         default:   return 1'b1;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      wls_d    = wls_q;
      pen_d    = pen_q;
      stb_d    = stb_q;
      pop_d    = 1'b0;

      if (baudout_i) begin
         case (state_q)
            ST_IDLE: begin
               if (!empty_i) begin
                  pop_d   = 1'b1;
                  shift_d = d_i;
                  wls_d   = csr_i.lcr.wls;
                  pen_d   = csr_i.lcr.pen;
                  stb_d   = csr_i.lcr.stb;
                  par_d   = parity_bit(d_i, csr_i.lcr.wls, csr_i.lcr.eps,
                                       csr_i.lcr.stick_parity);
                  cnt_d   = BIT_TICKS_M1;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (cnt_q == 5'd0) begin
                  state_d  = ST_BYTE;
                  bitcnt_d = 3'(wls_q) + 3'd4;
                  cnt_d    = BIT_TICKS_M1;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            ST_BYTE: begin
               if (cnt_q == 5'd0) begin
                  shift_d = shift_q >> 1;
                  cnt_d   = BIT_TICKS_M1;
                  if (bitcnt_q == 3'd0) begin
                     if (pen_q) begin
                        state_d = ST_PARITY;
                     end else begin
                        state_d = ST_STOP;
                        cnt_d   = stop_reload(stb_q, wls_q);
                     end
                  end else begin
                     bitcnt_d = bitcnt_q - 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            ST_PARITY: begin
               if (cnt_q == 5'd0) begin
                  state_d = ST_STOP;
                  cnt_d   = stop_reload(stb_q, wls_q);
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            ST_STOP: begin
               if (cnt_q == 5'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Line level is derived from the next state so the register changes in
      // the same edge as the FSM; break overrides it on any clock.
      sout_d = csr_i.lcr.bc ? 1'b0 : line_level(state_d, shift_d[0], par_d);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         bitcnt_q <= 3'd0;
         shift_q  <= 8'd0;
         par_q    <= 1'b0;
         wls_q    <= wls_5bits;
         pen_q    <= 1'b0;
         stb_q    <= 1'b0;
         pop_q    <= 1'b0;
         sout_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         wls_q    <= wls_d;
         pen_q    <= pen_d;
         stb_q    <= stb_d;
         pop_q    <= pop_d;
         sout_q   <= sout_d;
      end
   end

   assign pop_o  = pop_q;
   assign sout_o = sout_q;
   assign temt_o = (state_q == ST_IDLE) && empty_i;

endmodule

// File: tb/tb_uart16550_tx.sv
// Directed testbench for uart16550_tx: frames for several formats, stop
// lengths, parity modes, back-to-back characters, break and mid-frame reset.
module tb_uart16550_tx;
   import uart16550_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud;
   csr_t       csr;
   logic       empty;
   logic [7:0] d;
   logic       pop, temt, sout;

   int vec_cnt = 0;
   int err_cnt = 0;
   int pop_cnt = 0;
   int p0;

   uart16550_tx dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .baudout_i (baud),
      .csr_i     (csr),
      .empty_i   (empty),
      .d_i       (d),
      .pop_o     (pop),
      .temt_o    (temt),
      .sout_o    (sout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (pop) pop_cnt++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One baud tick followed by one idle clock; sample after the idle clock.
   task automatic do_tick();
      baud = 1'b1;
      @(posedge clk); #1;
      baud = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic set_lcr(input wls_t wls, input logic pen, input logic eps,
                          input logic stick, input logic stb);
      csr.lcr.wls          = wls;
      csr.lcr.pen          = pen;
      csr.lcr.eps          = eps;
      csr.lcr.stick_parity = stick;
      csr.lcr.stb          = stb;
      csr.lcr.bc           = 1'b0;
   endtask

   // lv[i] is the line level of bit slot i (start first) before the stop bit.
   // After the pop, csr and d_i are scrambled to prove the shadow copies rule.
   task automatic run_frame(input string tag, input logic [7:0] data,
                            input logic [15:0] lv, input int nlv, input int stop_ticks,
                            input int bc_from, input int bc_to);
      int n;
      logic e;
      n = nlv * 16 + stop_ticks;
      d = data;
      empty = 1'b0;
      p0 = pop_cnt;
      for (int k = 0; k <= n; k++) begin
         csr.lcr.bc = (k >= bc_from) && (k < bc_to);
         do_tick();
         if (k == 0) begin
            empty = 1'b1;
            d = ~data;
            csr.lcr.wls = wls_t'(~csr.lcr.wls);
            csr.lcr.pen = ~csr.lcr.pen;
            csr.lcr.eps = ~csr.lcr.eps;
            csr.lcr.stick_parity = ~csr.lcr.stick_parity;
            csr.lcr.stb = ~csr.lcr.stb;
         end
         if (csr.lcr.bc)      e = 1'b0;
         else if (k < nlv*16) e = lv[k/16];
         else                 e = 1'b1;
         check({tag, " sout"}, 16'(sout), 16'(e));
         check({tag, " temt"}, 16'(temt), 16'(k == n));
      end
      csr.lcr.bc = 1'b0;
      check({tag, " pops"}, 16'(pop_cnt - p0), 16'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      baud  = 1'b0;
      empty = 1'b1;
      d     = 8'h00;
      set_lcr(wls_8bits, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst sout", 16'(sout), 16'd1);
      check("rst pop",  16'(pop),  16'd0);
      check("rst temt empty=1", 16'(temt), 16'd1);
      empty = 1'b0; #1;
      check("rst temt empty=0", 16'(temt), 16'd0);
      empty = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_tick(); do_tick();
      check("idle sout", 16'(sout), 16'd1);
      check("idle no pop", 16'(pop_cnt), 16'd0);

      set_lcr(wls_8bits, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("8N1 55", 8'h55, 16'h00AA, 9, 16, -1, -1);

      set_lcr(wls_7bits, 1'b1, 1'b1, 1'b0, 1'b0);
      run_frame("7E1 A3", 8'hA3, 16'h0146, 9, 16, -1, -1);

      set_lcr(wls_5bits, 1'b0, 1'b0, 1'b0, 1'b1);
      run_frame("5N1.5 1F", 8'h1F, 16'h003E, 6, 24, -1, -1);

      set_lcr(wls_8bits, 1'b0, 1'b0, 1'b0, 1'b1);
      run_frame("8N2 1F", 8'h1F, 16'h003E, 9, 32, -1, -1);

      set_lcr(wls_6bits, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame("6O1 47", 8'h47, 16'h000E, 8, 16, -1, -1);

      set_lcr(wls_8bits, 1'b1, 1'b0, 1'b1, 1'b0);
      run_frame("8 stick1 00", 8'h00, 16'h0200, 10, 16, -1, -1);

      set_lcr(wls_8bits, 1'b1, 1'b1, 1'b1, 1'b0);
      run_frame("8 stick0 FF", 8'hFF, 16'h01FE, 10, 16, -1, -1);

      set_lcr(wls_8bits, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("8N1 break", 8'h0F, 16'h001E, 9, 16, 40, 80);

      // Back-to-back: 0x00 then 0xFF; second start one tick after first stop.
      set_lcr(wls_8bits, 1'b0, 1'b0, 1'b0, 1'b0);
      d = 8'h00;
      empty = 1'b0;
      p0 = pop_cnt;
      for (int k = 0; k <= 321; k++) begin
         logic e;
         do_tick();
         if (k == 0)   d = 8'hFF;
         if (k == 161) empty = 1'b1;
         if (k < 144)      e = 1'b0;
         else if (k < 161) e = 1'b1;
         else if (k < 177) e = 1'b0;
         else              e = 1'b1;
         check("b2b sout", 16'(sout), 16'(e));
         check("b2b temt", 16'(temt), 16'(k == 321));
      end
      check("b2b pops", 16'(pop_cnt - p0), 16'd2);

      // Reset in the middle of a data bit.
      d = 8'hAA;
      empty = 1'b0;
      p0 = pop_cnt;
      for (int k = 0; k <= 40; k++) begin
         do_tick();
         if (k == 0) empty = 1'b1;
      end
      check("pre-rst sout", 16'(sout), 16'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst sout", 16'(sout), 16'd1);
      check("midrst pop",  16'(pop),  16'd0);
      check("midrst temt", 16'(temt), 16'd1);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         do_tick();
         check("postrst sout", 16'(sout), 16'd1);
      end
      check("postrst pops", 16'(pop_cnt - p0), 16'd1);
      set_lcr(wls_8bits, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("8N1 after rst", 8'h55, 16'h00AA, 9, 16, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
